btn_event_queue: RTL

Downstream of the five-button debouncer. Converts each debounced button press (0→1 transition on the debouncer's `btn_o`) into a one-byte ASCII event code. Codes are buffered in a small FIFO and handed to the UART transmit path over a valid/ready handshake. Simultaneous presses are serialized lowest-index first; lost presses raise a sticky overflow flag.

---
 rtl/btn_event_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/btn_event_queue.sv
// -----------------------------------------------------------------------------
// btn_event_queue
//
// Turns debounced button presses (0->1 transitions on btn_i) into one-byte
// event codes (CODE_BASE + button index) and queues them in a small FIFO.
// The FIFO drains to a consumer over a valid/ready handshake. Presses that
// arrive together are serialized lowest index first. A press that arrives
// while the same button still has an unqueued press waiting is lost and sets
// a sticky overflow flag.
//
// Ports:
//   clk         in   1  clock, all state on the rising edge
//   rst_n       in   1  asynchronous active-low reset
//   btn_i       in   5  debounced button levels, synchronous to clk
//   data_o      out  8  event code at FIFO head, meaningful while valid_o=1
//   valid_o     out  1  FIFO non-empty
//   ready_i     in   1  consumer takes the head this cycle
//   overflow_o  out  1  sticky, a press was lost
// -----------------------------------------------------------------------------
module btn_event_queue #(
   parameter int          DEPTH_LOG2 = 3,
   parameter logic [7:0]  CODE_BASE  = 8'h30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  btn_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        overflow_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   // Count value meaning "full": the single MSB of the count register set.
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [4:0]            prev_q,     prev_d;
   logic [4:0]            pending_q,  pending_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q,   rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q,    count_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            mem_q [DEPTH];

   logic [4:0]            rise;
   logic [4:0]            sel_onehot;
   logic [4:0]            push_mask;
   logic [2:0]            sel;
   logic [7:0]            code;
   logic                  push;
   logic                  pop;

   // Lowest pending button wins; the loop runs high to low so the last
   // assignment is the lowest set index.
   always_comb begin
      sel = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel = 3'(i);
         end
      end
   end

   always_comb begin
      rise       = btn_i & ~prev_q;
      // Isolate the lowest set bit of pending (two's-complement trick).
      sel_onehot = pending_q & (~pending_q + 5'd1);
      // Push is blocked on a full FIFO even if a pop happens this cycle.
      push       = (pending_q != 5'd0) && (count_q != FULL_CNT);
      pop        = valid_o && ready_i;
      push_mask  = push ? sel_onehot : 5'd0;
      code       = CODE_BASE + {5'd0, sel};

      prev_d     = btn_i;
      // A rise on the bit being pushed re-sets it: it is a new event.
      pending_d  = (pending_q & ~push_mask) | rise;
      // A rise is lost only if its bit is still pending after this cycle's push.
      overflow_d = overflow_q | (|(rise & pending_q & ~push_mask));
      wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d    = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // All ones: a button held through reset exit must not fire.
         prev_q     <= 5'b11111;
         pending_q  <= 5'd0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         pending_q  <= pending_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage entries are cleared by reset so data_o reads 8'h00 out of reset.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_q[gi] <= 8'h00;
            end else if (push && (wr_ptr_q == DEPTH_LOG2'(gi))) begin
               mem_q[gi] <= code;
            end
         end
      end
   endgenerate

   assign data_o     = mem_q[rd_ptr_q];
   assign valid_o    = (count_q != '0);
   assign overflow_o = overflow_q;

endmodule
